mul_rr_scheduler: RTL and testbench

- Shares one pipelined 16x16 Wallace-tree multiplier among NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle into the multiplier.
- A tag pipeline runs alongside the multiplier so each product is routed back to the requester that issued it.
- Sits between requester blocks and the multiplier instance in the arithmetic subsystem.

---
 rtl/mul_sched_pkg.sv | 21 ++
 rtl/mul_rr_scheduler_if.sv | 31 +++
 rtl/rr_arbiter.sv | 65 ++++++
 rtl/mul_rr_scheduler.sv | 121 ++++++++++++
 tb/tb_mul_rr_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_sched_pkg.sv
// Shared widths, id-width helper and the tag type for the round-robin multiplier scheduler.
package mul_sched_pkg;

  localparam int OP_W    = 16;
  localparam int PROD_W  = 32;
  localparam int MAX_REQ = 8;

  // Width needed to hold an index into n requesters (never less than one bit).
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tags are sized for the largest supported requester count so the type stays fixed.
  localparam int TAG_ID_W = idWidth(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_rr_scheduler_if.sv
// Request, multiplier and response signals between requesters and the scheduler.
interface mul_rr_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import mul_sched_pkg::*;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [OP_W*NUM_REQ-1:0] req_a;
  logic [OP_W*NUM_REQ-1:0] req_b;
  logic                    hold;
  logic [OP_W-1:0]         mul_a;
  logic [OP_W-1:0]         mul_b;
  logic [PROD_W-1:0]       mul_product;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [PROD_W-1:0]       rsp_product;
  logic                    busy;

  // Requester / multiplier side.
  modport master (
    output req_valid, req_a, req_b, hold, mul_product,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_product, busy
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, hold, mul_product,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_product, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a pointer that
// moves past the winner whenever a grant is issued.
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                enable_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [TAG_ID_W-1:0] grantIdx_o
);

  localparam int PTR_W = idWidth(NUM_REQ);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic             found;
  int               grantSel;

  // Pick the first request at or above the pointer, otherwise the first one below it.
  always_comb begin
    found      = 1'b0;
    grantSel   = 0;
    grant_o    = '0;
    grantIdx_o = '0;
    if (enable_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (i >= int'(ptr_q))) begin
          found      = 1'b1;
          grantSel   = i;
          grant_o[i] = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (i < int'(ptr_q))) begin
          found      = 1'b1;
          grantSel   = i;
          grant_o[i] = 1'b1;
        end
      end
      grantIdx_o = TAG_ID_W'(grantSel);
    end
  end

  // A grant always coincides with a request, so any grant is a handshake that advances the pointer.
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (grantSel == NUM_REQ - 1) ? '0 : PTR_W'(grantSel + 1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one pipelined multiplier among NUM_REQ requesters. A tag pipeline
// matched to the multiplier latency routes each product back to its issuer.
module mul_rr_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3
) (
  input logic               clk,
  input logic               rst_n,
  mul_rr_scheduler_if.slave bus
);

  logic [NUM_REQ-1:0]  grant;
  logic [TAG_ID_W-1:0] grantIdx;
  logic                handshake;

  logic [OP_W-1:0]     mulA_d;
  logic [OP_W-1:0]     mulB_d;
  logic [OP_W-1:0]     mulA_q;
  logic [OP_W-1:0]     mulB_q;

  tag_t                issueTag_d;
  tag_t                issueTag_q;
  tag_t                tagPipe_q [MUL_LAT];
  tag_t                tagOut;
  logic                pipeAnyValid;

  logic [NUM_REQ-1:0]  rspValid_d;
  logic [NUM_REQ-1:0]  rspValid_q;
  logic [PROD_W-1:0]   rspProduct_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) uArbiter (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (bus.req_valid),
    .enable_i   (!bus.hold),
    .grant_o    (grant),
    .grantIdx_o (grantIdx)
  );

  assign bus.req_ready = grant;
  assign handshake     = |(bus.req_valid & grant);

  // Select the winner's operands; idle cycles send zeros and an invalid tag.
  always_comb begin
    mulA_d = '0;
    mulB_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] && bus.req_valid[i]) begin
        mulA_d = bus.req_a[OP_W*i +: OP_W];
        mulB_d = bus.req_b[OP_W*i +: OP_W];
      end
    end
    issueTag_d.valid = handshake;
    issueTag_d.id    = handshake ? grantIdx : '0;
  end

  // Issue register feeding the multiplier operands together with their tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mulA_q     <= '0;
      mulB_q     <= '0;
      issueTag_q <= '0;
    end else begin
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      issueTag_q <= issueTag_d;
    end
  end

  // Free-running tag shift register; the multiplier cannot stall so neither does this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        tagPipe_q[s] <= '0;
      end
    end else begin
      tagPipe_q[0] <= issueTag_q;
      for (int s = 1; s < MUL_LAT; s++) begin
        tagPipe_q[s] <= tagPipe_q[s-1];
      end
    end
  end

  assign tagOut = tagPipe_q[MUL_LAT-1];

  // Decode the exiting tag into a one-hot response and note any in-flight stage.
  always_comb begin
    rspValid_d   = '0;
    pipeAnyValid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rspValid_d[i] = tagOut.valid && (tagOut.id == TAG_ID_W'(i));
    end
    for (int s = 0; s < MUL_LAT; s++) begin
      pipeAnyValid = pipeAnyValid | tagPipe_q[s].valid;
    end
  end

  // Response register; the product is only captured when a live tag exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValid_q   <= '0;
      rspProduct_q <= '0;
    end else begin
      rspValid_q <= rspValid_d;
      if (tagOut.valid) begin
        rspProduct_q <= bus.mul_product;
      end
    end
  end

  assign bus.mul_a       = mulA_q;
  assign bus.mul_b       = mulB_q;
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_product = rspProduct_q;
  assign bus.busy        = issueTag_q.valid | pipeAnyValid | (|rspValid_q);

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Self-checking bench for mul_rr_scheduler: directed vectors plus a
// cycle-by-cycle reference model of arbitration and response timing.
module tb_mul_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 3;
  localparam int RSP_LAT = MUL_LAT + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   assertCount = 0;
  int   failCount   = 0;
  int   cyc         = 0;

  mul_rr_scheduler_if #(.NUM_REQ(NUM_REQ)) bus();

  mul_rr_scheduler #(
    .NUM_REQ (NUM_REQ),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the pipelined multiplier.
  logic [31:0] mulPipe [MUL_LAT];

  always @(posedge clk) begin
    mulPipe[0] <= 32'(bus.mul_a) * 32'(bus.mul_b);
    for (int s = 1; s < MUL_LAT; s++) mulPipe[s] <= mulPipe[s-1];
  end

  assign bus.mul_product = mulPipe[MUL_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: expected grants, responses and busy from the rules.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] prod;
  } exp_t;

  exp_t        expQ[$];
  int          modelPtr = 0;
  logic [31:0] lastProd = 32'h0;

  always @(negedge clk) begin
    logic [3:0] expGrant;
    logic [3:0] expRsp;
    logic       expBusy;
    int         gIdx;
    int         idx;
    if (!rst_n) begin
      expQ.delete();
      modelPtr = 0;
      lastProd = 32'h0;
      checkOutput("model_reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("model_reset_rsp_product", bus.rsp_product, 32'h0);
      checkOutput("model_reset_busy", 32'(bus.busy), 32'h0);
      checkOutput("model_reset_mul_a", 32'(bus.mul_a), 32'h0);
    end else begin
      expGrant = 4'b0;
      gIdx     = -1;
      if (!bus.hold) begin
        for (int off = 0; off < NUM_REQ; off++) begin
          idx = (modelPtr + off) % NUM_REQ;
          if (gIdx < 0 && bus.req_valid[idx]) gIdx = idx;
        end
      end
      if (gIdx >= 0) expGrant[gIdx] = 1'b1;
      checkOutput("model_req_ready", 32'(bus.req_ready), 32'(expGrant));

      expRsp = 4'b0;
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
        expRsp[expQ[0].id] = 1'b1;
        lastProd = expQ[0].prod;
        void'(expQ.pop_front());
      end
      checkOutput("model_rsp_valid", 32'(bus.rsp_valid), 32'(expRsp));
      checkOutput("model_rsp_product", bus.rsp_product, lastProd);

      expBusy = (expRsp != 4'b0);
      foreach (expQ[j]) if (expQ[j].due - (MUL_LAT + 1) <= cyc) expBusy = 1'b1;
      checkOutput("model_busy", 32'(bus.busy), 32'(expBusy));

      if (gIdx >= 0) begin
        expQ.push_back('{cyc + RSP_LAT, gIdx,
                         32'(bus.req_a[16*gIdx +: 16]) * 32'(bus.req_b[16*gIdx +: 16])});
        modelPtr = (gIdx + 1) % NUM_REQ;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] vld, input logic holdIn);
    bus.req_valid = vld;
    bus.hold      = holdIn;
    #1;
  endtask

  task automatic setOperands(input int idx, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*idx +: 16] = a;
    bus.req_b[16*idx +: 16] = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      nextCycle();
      applyStimulus(4'b0000, 1'b0);
    end
  endtask

  // Boundary operand pairs and their literal products, one per requester.
  logic [15:0] opA  [NUM_REQ] = '{16'hFFFF, 16'h8000, 16'h0000, 16'hAAAA};
  logic [15:0] opB  [NUM_REQ] = '{16'hFFFF, 16'h0002, 16'hFFFF, 16'h5555};
  logic [31:0] prodLit [NUM_REQ] = '{32'hFFFE0001, 32'h00010000, 32'h00000000, 32'h38E31C72};
  logic [31:0] sparseProd [6];

  // Directed stimulus sequence.
  initial begin
    logic [15:0] sa;
    logic [15:0] sb;
    logic [3:0]  expV;
    bus.req_valid = '0;
    bus.hold      = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    #2 rst_n = 1'b0;
    repeat (3) nextCycle();
    checkOutput("init_mul_a", 32'(bus.mul_a), 32'h0);
    checkOutput("init_mul_b", 32'(bus.mul_b), 32'h0);
    checkOutput("init_rsp_product", bus.rsp_product, 32'h0);
    checkOutput("init_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("init_busy", 32'(bus.busy), 32'h0);
    nextCycle();
    rst_n = 1'b1;
    idle(2);

    $display("[TB] reset with operations in flight");
    for (int i = 0; i < NUM_REQ; i++) setOperands(i, opA[i], opB[i]);
    nextCycle(); applyStimulus(4'b0111, 1'b0);
    checkOutput("flight_grant0", 32'(bus.req_ready), 32'h1);
    nextCycle(); applyStimulus(4'b0111, 1'b0);
    nextCycle(); applyStimulus(4'b0111, 1'b0);
    nextCycle(); applyStimulus(4'b0000, 1'b0);
    checkOutput("flight_busy_before_reset", 32'(bus.busy), 32'h1);
    nextCycle(); rst_n = 1'b0; #1;
    checkOutput("flight_reset_busy", 32'(bus.busy), 32'h0);
    nextCycle();
    nextCycle(); rst_n = 1'b1; #1;
    checkOutput("flight_release_rsp", 32'(bus.rsp_valid), 32'h0);
    for (int c = 0; c < 10; c++) begin
      nextCycle(); applyStimulus(4'b0000, 1'b0);
      checkOutput("flight_no_rsp", 32'(bus.rsp_valid), 32'h0);
      checkOutput("flight_not_busy", 32'(bus.busy), 32'h0);
    end
    nextCycle(); applyStimulus(4'b1111, 1'b0);
    checkOutput("post_reset_grant", 32'(bus.req_ready), 32'h1);
    idle(8);

    $display("[TB] single request");
    setOperands(1, 16'h1234, 16'h5678);
    nextCycle(); applyStimulus(4'b0010, 1'b0);
    checkOutput("single_grant", 32'(bus.req_ready), 32'h2);
    for (int d = 1; d <= 6; d++) begin
      nextCycle(); applyStimulus(4'b0000, 1'b0);
      checkOutput("single_rsp_valid", 32'(bus.rsp_valid), (d == 5) ? 32'h2 : 32'h0);
      if (d == 5) checkOutput("single_rsp_product", bus.rsp_product, 32'h06260060);
    end
    idle(4);

    $display("[TB] full contention with boundary operands");
    for (int i = 0; i < NUM_REQ; i++) setOperands(i, opA[i], opB[i]);
    nextCycle(); applyStimulus(4'b1000, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      nextCycle();
      applyStimulus((c < 8) ? 4'b1111 : 4'b0000, 1'b0);
      checkOutput("contention_grant", 32'(bus.req_ready), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
      if (c >= 5) begin
        checkOutput("contention_rsp_valid", 32'(bus.rsp_valid), 32'h1 << ((c - 5) % 4));
        checkOutput("contention_rsp_product", bus.rsp_product, prodLit[(c - 5) % 4]);
      end
    end
    idle(6);

    $display("[TB] hold");
    nextCycle(); applyStimulus(4'b1111, 1'b0);
    checkOutput("hold_grant0", 32'(bus.req_ready), 32'h1);
    nextCycle(); applyStimulus(4'b1111, 1'b0);
    checkOutput("hold_grant1", 32'(bus.req_ready), 32'h2);
    for (int c = 0; c < 4; c++) begin
      nextCycle(); applyStimulus(4'b1111, 1'b1);
      checkOutput("hold_no_grant", 32'(bus.req_ready), 32'h0);
    end
    nextCycle(); applyStimulus(4'b1111, 1'b0);
    checkOutput("hold_release_grant", 32'(bus.req_ready), 32'h4);
    idle(8);

    $display("[TB] sparse traffic on requester 3");
    for (int c = 0; c < 18; c++) begin
      nextCycle();
      if (c < 12 && (c % 2) == 0) begin
        sa = 16'(c * 16'h1357 + 16'h00FF);
        sb = 16'(16'hF00D - c * 16'h0321);
        setOperands(3, sa, sb);
        sparseProd[c/2] = 32'(sa) * 32'(sb);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("sparse_grant", 32'(bus.req_ready), 32'h8);
      end else begin
        applyStimulus(4'b0000, 1'b0);
      end
      expV = (c >= 5 && (c - 5) < 12 && ((c - 5) % 2) == 0) ? 4'b1000 : 4'b0000;
      checkOutput("sparse_rsp_valid", 32'(bus.rsp_valid), 32'(expV));
      if (expV != 4'b0000) checkOutput("sparse_rsp_product", bus.rsp_product, sparseProd[(c - 5) / 2]);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
